// File: rtl/lcd_pkg.sv
// lcd_pkg: shared constants, FSM/opcode types and address-counter helpers for the LCD bus responder
package lcd_pkg;
    localparam logic [6:0] DDRAM_DEPTH = 7'd80;
    localparam logic [6:0] LINE_LEN    = 7'd40;
    localparam logic [6:0] LINE2_BASE  = 7'h40;
    localparam logic [6:0] LINE1_END   = 7'h27;
    localparam logic [6:0] LINE2_END   = 7'h67;
    localparam logic [7:0] SPACE       = 8'h20;
    typedef enum logic [1:0] {IDLE, BUSY, CLEARING} state_t;
    typedef enum logic [3:0] {
        OP_NONE, OP_CLEAR, OP_HOME, OP_ENTRY, OP_DISP, OP_SHIFT, OP_FUNC, OP_CGRAM, OP_DDRAM
    } op_t;
    function automatic op_t op_decode(input logic [7:0] d);
        return d[7] ? OP_DDRAM : d[6] ? OP_CGRAM : d[5] ? OP_FUNC : d[4] ? OP_SHIFT :
               d[3] ? OP_DISP  : d[2] ? OP_ENTRY : d[1] ? OP_HOME : d[0] ? OP_CLEAR : OP_NONE;
    endfunction
    function automatic logic ac_legal(input logic [6:0] a);
        return a[5:0] < LINE_LEN[5:0];
    endfunction
    function automatic logic [6:0] ac_idx(input logic [6:0] a);
        return a[6] ? {1'b0, a[5:0]} + LINE_LEN : {1'b0, a[5:0]};
    endfunction
    // Steps stay inside the two legal windows, hopping between line ends.
    function automatic logic [6:0] ac_step(input logic [6:0] a, input logic inc);
        return inc ? (a == LINE1_END ? LINE2_BASE : a == LINE2_END ? 7'h00 : a + 7'd1)
                   : (a == 7'h00 ? LINE2_END : a == LINE2_BASE ? LINE1_END : a - 7'd1);
    endfunction
endpackage

// File: rtl/lcd_ddram.sv
// lcd_ddram: 80x8 display RAM with one write port, a combinational bus read and a registered host read
module lcd_ddram import lcd_pkg::*; (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       we,
    input  logic [6:0] waddr,
    input  logic [7:0] wdata,
    input  logic [6:0] bus_addr,
    output logic [7:0] bus_data,
    input  logic [6:0] rd_addr,
    output logic [7:0] rd_char
);
    logic [7:0] mem [DDRAM_DEPTH];
    always_ff @(posedge clk)
        if (we) mem[waddr] <= wdata;
    assign bus_data = bus_addr < DDRAM_DEPTH ? mem[bus_addr] : SPACE;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) rd_char <= '0;
        else        rd_char <= rd_addr < DDRAM_DEPTH ? mem[rd_addr] : SPACE;
endmodule

// File: rtl/lcd_bus_responder.sv
// lcd_bus_responder: HD44780-compatible device end of the 8-bit LCD bus with DDRAM, AC, mode flags and busy model
module lcd_bus_responder import lcd_pkg::*; #(
    parameter int BUSY_CYCLES  = 4,
    parameter int CLEAR_CYCLES = 160
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       lcd_rs,
    input  logic       lcd_rw,
    input  logic       lcd_en,
    input  logic [7:0] lcd_din,
    output logic [7:0] lcd_dout,
    output logic       lcd_dout_oe,
    output logic       busy,
    output logic [6:0] ac,
    output logic       disp_on, cursor_on, blink_on,
    output logic       entry_inc, entry_shift, two_line,
    output logic       cmd_dropped,
    input  logic [6:0] rd_addr,
    output logic [7:0] rd_char
);
    localparam int CW = $clog2(CLEAR_CYCLES + 1);
    logic [10:0]   sync1, sync2;
    logic          en_d, en_s, rs_s, rw_s;
    logic [7:0]    din_s, bus_data;
    logic          strobe, wr_stb, rd_stb, accept, long_op;
    logic [CW-1:0] cnt, cnt_n;
    logic [6:0]    clr_idx, ac_n;
    state_t        state, state_n;
    op_t           op;
    assign {en_s, rs_s, rw_s, din_s} = sync2;
    assign strobe      = en_d & ~en_s;
    assign wr_stb      = strobe & ~rw_s;
    assign rd_stb      = strobe & rw_s;
    assign busy        = cnt != '0;
    assign accept      = wr_stb & ~busy;
    assign cmd_dropped = wr_stb & busy;
    assign lcd_dout_oe = en_s & rw_s;
    assign lcd_dout    = lcd_dout_oe ? (rs_s ? bus_data : {busy, ac}) : '0;
    always_comb begin
        op      = op_decode(din_s);
        long_op = ~rs_s & (op == OP_CLEAR || op == OP_HOME);
        cnt_n   = accept ? (long_op ? CW'(CLEAR_CYCLES) : CW'(BUSY_CYCLES)) : busy ? cnt - CW'(1) : cnt;
        state_n = state == CLEARING ? (clr_idx == DDRAM_DEPTH - 7'd1 ? (cnt == CW'(1) ? IDLE : BUSY) : CLEARING)
                : accept ? (~rs_s && op == OP_CLEAR ? CLEARING : BUSY)
                : cnt <= CW'(1) ? IDLE : state;
        ac_n    = ac;
        if (accept && rs_s)
            ac_n = ac_step(ac, entry_inc);
        else if (accept)
            ac_n = long_op ? 7'h00
                 : (op == OP_SHIFT && !din_s[3]) ? ac_step(ac, din_s[2])
                 : (op == OP_DDRAM && ac_legal(din_s[6:0])) ? din_s[6:0] : ac;
        else if (rd_stb && rs_s && !busy)
            ac_n = ac_step(ac, entry_inc);
    end
    // Reset lands in CLEARING with the long busy count, so the power-on clear runs right after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
            en_d  <= 1'b0;
            state <= CLEARING;
            cnt   <= CW'(CLEAR_CYCLES);
            clr_idx <= '0;
            ac    <= '0;
            {disp_on, cursor_on, blink_on, entry_shift, two_line} <= '0;
            entry_inc <= 1'b1;
        end else begin
            sync1 <= {lcd_en, lcd_rs, lcd_rw, lcd_din};
            sync2 <= sync1;
            en_d  <= en_s;
            state <= state_n;
            cnt   <= cnt_n;
            clr_idx <= state == CLEARING ? clr_idx + 7'd1 : '0;
            ac    <= ac_n;
            if (accept && !rs_s) begin
                if (op == OP_CLEAR) entry_inc <= 1'b1;
                if (op == OP_ENTRY) {entry_inc, entry_shift} <= din_s[1:0];
                if (op == OP_DISP)  {disp_on, cursor_on, blink_on} <= din_s[2:0];
                if (op == OP_FUNC)  two_line <= din_s[3];
            end
        end
    end
    lcd_ddram u_ram (
        .clk      (clk),
        .rst_n    (rst_n),
        .we       (state == CLEARING || (accept && rs_s)),
        .waddr    (state == CLEARING ? clr_idx : ac_idx(ac)),
        .wdata    (state == CLEARING ? SPACE : din_s),
        .bus_addr (ac_idx(ac)),
        .bus_data (bus_data),
        .rd_addr  (rd_addr),
        .rd_char  (rd_char)
    );
endmodule

// File: doc/lcd_bus_responder.md
Name: lcd_bus_responder

Overview:
- Synthesizable HD44780-compatible responder: the device end of the 8-bit parallel LCD bus (rs, rw, en, data).
- Decodes instructions, maintains 80-byte DDRAM, address counter (AC) and mode flags, models busy timing, and drives read-back of busy/AC and DDRAM data.
- Used as on-chip display emulator and as the checking target for the LCD controller in system simulation.
- Exposes a host readout port for a character renderer.

Parameters:
BUSY_CYCLES, 4, clk cycles busy stays high after any accepted instruction or data write except clear/home
CLEAR_CYCLES, 160, busy length for clear, return-home and post-reset clear; must be >= 80

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
lcd_rs  in  1  register select (0 instruction, 1 data)
lcd_rw  in  1  0 write, 1 read
lcd_en  in  1  bus enable strobe, asynchronous to clk
lcd_din  in  8  bus data from controller
lcd_dout  out  8  bus read data
lcd_dout_oe  out  1  drive enable for lcd_dout
busy  out  1  busy flag
ac  out  7  address counter
disp_on, cursor_on, blink_on  out  1 each  display-control flags
entry_inc, entry_shift, two_line  out  1 each  I/D, S, N flags
cmd_dropped  out  1  one-cycle pulse when a write strobe is ignored because busy=1
rd_addr  in  7  host DDRAM index 0..79
rd_char  out  8  DDRAM[rd_addr], registered, 1-cycle latency

Behaviour:
- Reset: all outputs 0 except entry_inc=1 and busy=1; ac=0x00. Post-reset clear starts on the first clk after rst_n rises.
- Reset mid-clear aborts the sequence; it restarts from index 0 after release.
- Synchronisation: lcd_en, lcd_rs, lcd_rw and lcd_din pass through a 2-flop synchroniser. The falling edge of synced en is the strobe. All strobe actions take effect on the strobe cycle.
- Address map: idx = ac[6]*40 + ac[5:0]. Legal ac values are 0x00-0x27 and 0x40-0x67.
- Increment wraps 0x27->0x40 and 0x67->0x00. Decrement wraps 0x00->0x67 and 0x40->0x27.
- Write strobe (rw=0) with busy=1: ignored, cmd_dropped pulses.
- Write strobe with busy=0 and rs=1: DDRAM[idx]<=din, ac steps per entry_inc, busy for BUSY_CYCLES.
- Instruction decode (rs=0), by highest set bit of din:
  - 0x01 clear: writes 0x20 to DDRAM index 0..79, one per cycle; ac=0; entry_inc=1; busy for CLEAR_CYCLES.
  - 0x02/03 home: ac=0; busy for CLEAR_CYCLES.
  - 0x04-07: entry_inc=din[1], entry_shift=din[0].
  - 0x08-0F: disp_on=din[2], cursor_on=din[1], blink_on=din[0].
  - 0x10-1F: if din[3]=0, cursor move: ac steps right (din[2]=1) or left; display shift is accepted with no effect on ac.
  - 0x20-3F: two_line=din[3]; din[4] and din[2] ignored.
  - 0x40-7F: CGRAM address, accepted, no state change.
  - 0x80-FF: ac=din[6:0] if legal; illegal value leaves ac unchanged.
  - Every accepted instruction asserts busy for BUSY_CYCLES unless stated otherwise above.
- Read (rw=1), while synced en=1:
  - lcd_dout_oe=1.
  - rs=0: lcd_dout={busy, ac}, valid regardless of busy.
  - rs=1: lcd_dout=DDRAM[idx]. On the strobe ac steps per entry_inc, only if busy=0.
  - lcd_dout_oe falls on the cycle synced en falls.
- busy counter is a down-counter; busy = counter != 0. A new strobe cannot load it while nonzero.
- rd_addr >= 80 returns 0x20.

Decomposition:
- lcd_pkg: instruction opcode masks, DDRAM_DEPTH=80, LINE2_BASE=0x40, LINE_LEN=40, space code 0x20, ac step/wrap function.
- Sub-module lcd_ddram: 80x8 RAM, one write port and two read ports (bus read combinational, host read registered).
- The FSM (IDLE, BUSY, CLEARING) stays in lcd_bus_responder.

Test Plan:
- Reset release -> busy=1 for 160 cycles, then 0; rd_char=0x20 at indices 0, 40, 79; ac=0x00.
- Strobe 0x38, 0x01, 0x0E, 0x06, 0x80, then data 76 65 72 69 6C 6F 67, each after busy=0 -> two_line=1, disp_on=1, cursor_on=1, blink_on=0, entry_inc=1; DDRAM[0..6] holds "verilog"; ac=0x07.
- Instruction 0xA7, data 0x41 -> DDRAM[39]=0x41, ac=0x40. Then 0xE7, data 0x42 -> DDRAM[79]=0x42, ac=0x00.
- Instruction 0x04, 0x80, data 0x43 -> DDRAM[0]=0x43, ac=0x67. Instruction 0xA8 -> ac unchanged.
- Data strobe 0x55 one cycle after a previous write -> cmd_dropped pulses once; DDRAM unchanged.
- Read rs=0 during busy at ac=0x02 -> lcd_dout=0x82. Read rs=1 at ac=0x02 after busy=0 with "verilog" loaded -> lcd_dout=0x72, ac=0x03 after en falls. rst_n pulse mid-clear -> clear restarts and busy lasts the full 160 cycles.
